// File: rtl/tmds_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tmds_shift_sequencer
//
// Serialises 10-bit TMDS symbols (red, green, blue) into 1-bit (SDR) or
// 2-bit (DDR) slices per clk_shift cycle. It also produces the matching
// TMDS clock-channel pattern. A one-deep shadow (skid) register decouples
// the upstream encoder from the symbol boundary. When no symbol is waiting
// at a boundary, the idle control symbol is sent instead and a sticky
// underrun flag is raised.
//
// Handshake: a triplet transfers on every rising clk_shift edge where
// in_valid and in_ready are both high. in_ready is derived from registered
// state and reset only; it never looks at in_valid. in_* only need to be
// stable in the transfer cycle.
//
// Optional feature: define TMDS_UNDERRUN_COUNT_EN to add underrun_count,
// a saturating count of inserted idle symbols.
//
// Parameters:
//   C_ddr          0: SDR, 10 cycles per symbol; 1: DDR, 5 cycles per symbol
//   C_idle_symbol  symbol sent on underrun and after reset
//
// Ports:
//   clk_shift       bit/shift clock, the only clock
//   reset           synchronous, active-high
//   in_valid        upstream triplet valid
//   in_ready        triplet accepted this cycle when in_valid is high
//   in_red/green/blue  10-bit TMDS symbols
//   clr_underrun    clears the sticky underrun flag (and the counter)
//   out_clock       clock-channel slice, [0] first in time, [1] second
//   out_red/green/blue colour slices, same bit order
//   underrun        sticky: an idle symbol was inserted
//   underrun_count  (TMDS_UNDERRUN_COUNT_EN only) saturating idle count
// ---------------------------------------------------------------------------
module tmds_shift_sequencer #(
  parameter logic       C_ddr         = 1'b0,
  parameter logic [9:0] C_idle_symbol = 10'b1101010100
) (
  input  logic       clk_shift,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_red,
  input  logic [9:0] in_green,
  input  logic [9:0] in_blue,
  input  logic       clr_underrun,
  output logic [1:0] out_clock,
  output logic [1:0] out_red,
  output logic [1:0] out_green,
  output logic [1:0] out_blue,
  output logic       underrun
`ifdef TMDS_UNDERRUN_COUNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  // Last phase of a symbol: 4 in DDR (2 bits/cycle), 9 in SDR.
  localparam logic [3:0] PH_LAST       = C_ddr ? 4'd4 : 4'd9;
  // Five ones then five zeros, sent LSB first like the colour symbols.
  localparam logic [9:0] CLOCK_PATTERN = 10'b0000011111;

  // Slice of a symbol belonging to phase p, [0] is the earlier bit.
  function automatic logic [1:0] slice_at(input logic [9:0] sym,
                                          input logic [3:0] p);
    logic [3:0] idx_lo;
    logic [3:0] idx_hi;
    idx_lo = {p[2:0], 1'b0};
    idx_hi = {p[2:0], 1'b1};
    if (C_ddr) begin
      slice_at = {sym[idx_hi], sym[idx_lo]};
    end else begin
      slice_at = {1'b0, sym[p]};
    end
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [3:0] ph;
  logic [9:0] shift_red;
  logic [9:0] shift_green;
  logic [9:0] shift_blue;
  logic [9:0] shadow_red;
  logic [9:0] shadow_green;
  logic [9:0] shadow_blue;
  logic       shadow_full;
  logic       underrun_q;

  logic [3:0] ph_next;
  logic [9:0] shift_red_next;
  logic [9:0] shift_green_next;
  logic [9:0] shift_blue_next;
  logic [9:0] shadow_red_next;
  logic [9:0] shadow_green_next;
  logic [9:0] shadow_blue_next;
  logic       shadow_full_next;
  logic       underrun_next;

  logic       boundary;
  logic       accept;
  logic       inserting;

  // -------------------------------------------------------------------------
  // Handshake and boundary decode
  // -------------------------------------------------------------------------
  assign boundary = (ph == PH_LAST);
  // At the boundary the shadow empties into shift on the same edge, so a
  // full shadow can still take a new word in that cycle.
  assign in_ready = ~reset & (~shadow_full | boundary);
  assign accept   = in_valid & in_ready;
  // An idle symbol is inserted when the boundary finds nothing waiting.
  assign inserting = boundary & ~shadow_full;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    ph_next           = ph + 4'd1;
    shift_red_next    = shift_red;
    shift_green_next  = shift_green;
    shift_blue_next   = shift_blue;
    shadow_red_next   = shadow_red;
    shadow_green_next = shadow_green;
    shadow_blue_next  = shadow_blue;
    shadow_full_next  = shadow_full;
    underrun_next     = underrun_q;

    if (boundary) begin
      ph_next = 4'd0;
      if (shadow_full) begin
        shift_red_next   = shadow_red;
        shift_green_next = shadow_green;
        shift_blue_next  = shadow_blue;
        shadow_full_next = 1'b0;
      end else begin
        shift_red_next   = C_idle_symbol;
        shift_green_next = C_idle_symbol;
        shift_blue_next  = C_idle_symbol;
      end
    end

    // A same-cycle accept refills the shadow after the old content has
    // been handed to shift, so the new word becomes the following symbol.
    if (accept) begin
      shadow_red_next   = in_red;
      shadow_green_next = in_green;
      shadow_blue_next  = in_blue;
      shadow_full_next  = 1'b1;
    end

    // Setting wins over a coincident clear.
    if (inserting) begin
      underrun_next = 1'b1;
    end else if (clr_underrun) begin
      underrun_next = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_shift) begin
    if (reset) begin
      ph           <= 4'd0;
      shift_red    <= C_idle_symbol;
      shift_green  <= C_idle_symbol;
      shift_blue   <= C_idle_symbol;
      shadow_red   <= C_idle_symbol;
      shadow_green <= C_idle_symbol;
      shadow_blue  <= C_idle_symbol;
      shadow_full  <= 1'b0;
      underrun_q   <= 1'b0;
      out_clock    <= 2'b00;
      out_red      <= 2'b00;
      out_green    <= 2'b00;
      out_blue     <= 2'b00;
    end else begin
      ph           <= ph_next;
      shift_red    <= shift_red_next;
      shift_green  <= shift_green_next;
      shift_blue   <= shift_blue_next;
      shadow_red   <= shadow_red_next;
      shadow_green <= shadow_green_next;
      shadow_blue  <= shadow_blue_next;
      shadow_full  <= shadow_full_next;
      underrun_q   <= underrun_next;
      // Output slices use the current phase and the symbol currently in
      // shift, one cycle after ph; a boundary load only affects the next
      // cycle's slice.
      out_clock    <= slice_at(CLOCK_PATTERN, ph);
      out_red      <= slice_at(shift_red, ph);
      out_green    <= slice_at(shift_green, ph);
      out_blue     <= slice_at(shift_blue, ph);
    end
  end

  assign underrun = underrun_q;

`ifdef TMDS_UNDERRUN_COUNT_EN
  // -------------------------------------------------------------------------
  // Saturating idle-insertion counter
  // -------------------------------------------------------------------------
  logic [15:0] count_q;
  logic [15:0] count_next;

  always_comb begin
    count_next = count_q;
    if (clr_underrun) begin
      count_next = inserting ? 16'd1 : 16'd0;
    end else if (inserting && (count_q != 16'hFFFF)) begin
      count_next = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_shift) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_next;
    end
  end

  assign underrun_count = count_q;
`endif

endmodule

// File: tb/tb_tmds_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tmds_shift_sequencer
//
// Drives an SDR instance (lane 0) and a DDR instance (lane 1) side by side.
// A behavioural model per lane (phase count, FIFO of accepted triplets,
// symbol in flight) predicts every output cycle by cycle; a set of literal
// expectations pins the idle pattern, clock pattern and directed cases.
// ---------------------------------------------------------------------------
module tb_tmds_shift_sequencer;

  localparam logic [9:0] IDLE = 10'b1101010100;
  localparam logic [9:0] CLKP = 10'b0000011111;

  // clock
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals, index 0 = SDR, index 1 = DDR
  logic [1:0] rst;
  logic [1:0] in_valid;
  logic [1:0] clr;
  logic [1:0] in_ready;
  logic [1:0] underrun;
  logic [9:0] in_red [2];
  logic [9:0] in_green [2];
  logic [9:0] in_blue [2];
  logic [1:0] out_clock [2];
  logic [1:0] out_red [2];
  logic [1:0] out_green [2];
  logic [1:0] out_blue [2];
`ifdef TMDS_UNDERRUN_COUNT_EN
  logic [15:0] ucount [2];
`endif

  tmds_shift_sequencer #(.C_ddr(1'b0), .C_idle_symbol(IDLE)) dut_sdr (
    .clk_shift(clk), .reset(rst[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_red(in_red[0]), .in_green(in_green[0]),
    .in_blue(in_blue[0]), .clr_underrun(clr[0]), .out_clock(out_clock[0]),
    .out_red(out_red[0]), .out_green(out_green[0]), .out_blue(out_blue[0]),
    .underrun(underrun[0])
`ifdef TMDS_UNDERRUN_COUNT_EN
    , .underrun_count(ucount[0])
`endif
  );

  tmds_shift_sequencer #(.C_ddr(1'b1), .C_idle_symbol(IDLE)) dut_ddr (
    .clk_shift(clk), .reset(rst[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_red(in_red[1]), .in_green(in_green[1]),
    .in_blue(in_blue[1]), .clr_underrun(clr[1]), .out_clock(out_clock[1]),
    .out_red(out_red[1]), .out_green(out_green[1]), .out_blue(out_blue[1]),
    .underrun(underrun[1])
`ifdef TMDS_UNDERRUN_COUNT_EN
    , .underrun_count(ucount[1])
`endif
  );

  // model state
  int          m_ph [2];
  logic [29:0] m_cur [2];            // {red, green, blue} in flight
  logic [29:0] fifo [2][0:4095];     // accepted, not yet transmitted
  int          wr [2];
  int          rd [2];
  logic        m_und [2];
  logic [7:0]  m_out [2];            // {clock, red, green, blue} slices
  int          m_cnt [2];
  int          accepted [2];

  // stimulus control
  int          mode [2];             // 0 none, 1 held word, 2 random
  logic [29:0] held [2];
  int          dens [2];

  int compared;
  int mismatched;

  function automatic int nsym(input int l);
    return (l == 0) ? 10 : 5;
  endfunction

  function automatic logic [1:0] sl(input logic [9:0] s, input int p, input int l);
    logic [9:0] t;
    if (l == 1) begin
      t = s >> (2 * p);
      return t[1:0];
    end
    t = s >> p;
    return {1'b0, t[0]};
  endfunction

  function automatic logic model_ready(input int l);
    return !rst[l] && ((wr[l] == rd[l]) || (m_ph[l] == nsym(l) - 1));
  endfunction

  task automatic chk(input string name, input int l,
                     input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s lane%0d actual=%0h required=%0h at %0t",
               name, l, act, exp, $time);
    end
  endtask

  // Apply what the upcoming edge does, using the inputs now driven.
  task automatic model_update(input int l);
    logic rdy, acc, bnd, empty;
    if (rst[l]) begin
      m_ph[l]  = 0;
      m_cur[l] = {IDLE, IDLE, IDLE};
      rd[l]    = wr[l];
      m_und[l] = 1'b0;
      m_out[l] = 8'h00;
      m_cnt[l] = 0;
      return;
    end
    rdy   = model_ready(l);
    acc   = in_valid[l] && rdy;
    bnd   = (m_ph[l] == nsym(l) - 1);
    empty = (wr[l] == rd[l]);
    m_out[l] = {sl(CLKP, m_ph[l], l), sl(m_cur[l][29:20], m_ph[l], l),
                sl(m_cur[l][19:10], m_ph[l], l), sl(m_cur[l][9:0], m_ph[l], l)};
    if (bnd) begin
      if (!empty) begin
        m_cur[l] = fifo[l][rd[l] % 4096];
        rd[l]++;
      end else begin
        m_cur[l] = {IDLE, IDLE, IDLE};
      end
    end
    if (bnd && empty) m_und[l] = 1'b1;
    else if (clr[l]) m_und[l] = 1'b0;
    if (clr[l]) m_cnt[l] = (bnd && empty) ? 1 : 0;
    else if (bnd && empty && m_cnt[l] < 65535) m_cnt[l]++;
    if (acc) begin
      fifo[l][wr[l] % 4096] = {in_red[l], in_green[l], in_blue[l]};
      wr[l]++;
      accepted[l]++;
    end
    m_ph[l] = (m_ph[l] + 1) % nsym(l);
  endtask

  task automatic compare_all();
    for (int l = 0; l < 2; l++) begin
      chk("out_clock", l, out_clock[l], m_out[l][7:6]);
      chk("out_red",   l, out_red[l],   m_out[l][5:4]);
      chk("out_green", l, out_green[l], m_out[l][3:2]);
      chk("out_blue",  l, out_blue[l],  m_out[l][1:0]);
      chk("in_ready",  l, in_ready[l],  model_ready(l));
      chk("underrun",  l, underrun[l],  m_und[l]);
`ifdef TMDS_UNDERRUN_COUNT_EN
      chk("underrun_count", l, ucount[l], m_cnt[l]);
`endif
    end
  endtask

  // driver: set this cycle's inputs per lane mode
  task automatic drive_all();
    for (int l = 0; l < 2; l++) begin
      in_red[l]   = 10'($urandom);
      in_green[l] = 10'($urandom);
      in_blue[l]  = 10'($urandom);
      clr[l]      = 1'b0;
      case (mode[l])
        1: begin
          in_valid[l] = 1'b1;
          {in_red[l], in_green[l], in_blue[l]} = held[l];
        end
        2: begin
          in_valid[l] = ($urandom_range(0, 99) < dens[l]);
          clr[l]      = ($urandom_range(0, 49) == 0);
        end
        default: in_valid[l] = 1'b0;
      endcase
    end
  endtask

  // one clock: model, edge, then compare away from the edge
  task automatic step();
    for (int l = 0; l < 2; l++) model_update(l);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  logic [9:0] idle_v;
  logic [1:0] ddr_idle [5];
  int hits;
  int rdy_cnt;
  int target0, target1;

  initial begin
    compared   = 0;
    mismatched = 0;
    idle_v     = IDLE;
    ddr_idle   = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    for (int l = 0; l < 2; l++) begin
      wr[l] = 0; rd[l] = 0; accepted[l] = 0; mode[l] = 0; dens[l] = 70;
      held[l] = '0; m_ph[l] = 0; m_cur[l] = {IDLE, IDLE, IDLE};
      m_und[l] = 1'b0; m_out[l] = 8'h00; m_cnt[l] = 0;
    end
    in_valid = 2'b00;
    clr      = 2'b00;

    // reset, then idle stream with literal pattern checks
    rst = 2'b11;
    repeat (3) begin drive_all(); step(); end
    chk("reset_out_red", 0, out_red[0], 2'b00);
    chk("reset_ready", 1, in_ready[1], 1'b0);
    rst = 2'b00;
    for (int j = 0; j < 30; j++) begin
      drive_all();
      step();
      chk("sdr_idle_bit", 0, out_red[0][0], idle_v[j % 10]);
      chk("sdr_clock_bit", 0, out_clock[0][0], ((j % 10) < 5));
      chk("sdr_upper_zero", 0, {out_clock[0][1], out_red[0][1],
                                out_green[0][1], out_blue[0][1]}, 4'b0000);
      chk("ddr_idle_slice", 1, out_blue[1], ddr_idle[j % 5]);
      if (j == 0) chk("first_ready", 0, in_ready[0], 1'b1);
      if (j == 8) chk("sdr_no_underrun_yet", 0, underrun[0], 1'b0);
      if (j == 9) chk("sdr_underrun_first_boundary", 0, underrun[0], 1'b1);
    end

    // DDR held constant data, SDR random
    mode[0] = 2;
    mode[1] = 1;
    held[1] = {10'h3FF, 10'h000, 10'h155};
    rdy_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      drive_all();
      if (j == 10) clr[1] = 1'b1;
      step();
      if (j >= 15) begin
        rdy_cnt += int'(in_ready[1]);
        chk("ddr_red_ones", 1, out_red[1], 2'b11);
        chk("ddr_green_zeros", 1, out_green[1], 2'b00);
        chk("ddr_blue_0x155", 1, out_blue[1], 2'b01);
      end
    end
    chk("ddr_ready_pulses", 1, rdy_cnt, 5);
    chk("ddr_no_underrun", 1, underrun[1], 1'b0);

    // DDR: one triplet between idle symbols
    mode[1] = 0;
    repeat (20) begin drive_all(); step(); end
    mode[1] = 1;
    drive_all();
    step();
    mode[1] = 0;
    hits = 0;
    for (int j = 0; j < 30; j++) begin
      drive_all();
      step();
      if (out_red[1] == 2'b11 && out_green[1] == 2'b00 && out_blue[1] == 2'b01)
        hits++;
    end
    chk("one_symbol_cycles", 1, hits, 5);
    chk("underrun_after_single", 1, underrun[1], 1'b1);
    for (int k = 0; k < 10 && m_ph[1] != 0; k++) begin drive_all(); step(); end
    drive_all();
    clr[1] = 1'b1;
    step();
    chk("clr_underrun", 1, underrun[1], 1'b0);

    // random scoreboard: 1000 symbols per lane, random gaps
    mode[0]  = 2;
    mode[1]  = 2;
    target0  = accepted[0] + 1000;
    target1  = accepted[1] + 1000;
    for (int c = 0; c < 40000; c++) begin
      if (accepted[0] >= target0 && accepted[1] >= target1) break;
      if (c % 300 == 0) begin
        dens[0] = $urandom_range(5, 100);
        dens[1] = $urandom_range(5, 100);
      end
      drive_all();
      step();
    end
    chk("random_accepts", 0, (accepted[0] >= target0), 1'b1);
    chk("random_accepts", 1, (accepted[1] >= target1), 1'b1);

    // reset in the middle of a DDR data symbol
    mode[1] = 1;
    held[1] = {10'h0F0, 10'h3C3, 10'h2AA};
    repeat (12) begin drive_all(); step(); end
    for (int k = 0; k < 10 && m_ph[1] != 3; k++) begin drive_all(); step(); end
    chk("reset_at_ph3", 1, m_ph[1], 3);
    rst[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_all();
      step();
      chk("midreset_zero", 1, {out_clock[1], out_red[1], out_green[1], out_blue[1]}, 8'h00);
      chk("midreset_ready", 1, in_ready[1], 1'b0);
    end
    rst[1]  = 1'b0;
    mode[1] = 0;
    for (int j = 0; j < 10; j++) begin
      drive_all();
      step();
      chk("post_reset_idle_red", 1, out_red[1], ddr_idle[j % 5]);
      chk("post_reset_idle_green", 1, out_green[1], ddr_idle[j % 5]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tmds_shift_sequencer.md
Name: tmds_shift_sequencer

Overview:
- Sequences 10-bit TMDS symbols for red, green and blue into 1-bit (SDR) or 2-bit (DDR) slices per clk_shift cycle.
- Generates the matching TMDS clock-channel pattern.
- Its 2-bit slice outputs drive the fake differential output stage directly.
- Has a one-deep skid buffer with valid/ready handshake toward the TMDS encoder. Underruns are filled with a control symbol and flagged.

Parameters:
- C_ddr, 1'b0, 0: SDR (10 cycles per symbol); 1: DDR (5 cycles per symbol).
- C_idle_symbol, 10'b1101010100, symbol sent on underrun and after reset (control period, hsync=vsync=0).

Ports:
- clk_shift  in  1  bit/shift clock; the only clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream symbol triplet valid.
- in_ready  out  1  block accepts the triplet this cycle.
- in_red  in  10  TMDS symbol, red channel.
- in_green  in  10  TMDS symbol, green channel.
- in_blue  in  10  TMDS symbol, blue channel.
- clr_underrun  in  1  clears the sticky underrun flag.
- out_clock  out  2  clock-channel slice; [0] first in time, [1] second.
- out_red  out  2  red slice, same bit order.
- out_green  out  2  green slice, same bit order.
- out_blue  out  2  blue slice, same bit order.
- underrun  out  1  sticky: an idle symbol was inserted.

Behaviour:
- N = 10 if C_ddr=0, else 5. Phase counter ph runs 0..N-1 and wraps to 0.
- Shift registers: one 10-bit register per colour, plus a constant clock pattern 10'b0000011111. All are transmitted LSB first.
- Shadow registers: three 10-bit registers plus a shadow_full flag.
- in_ready = !shadow_full | (ph==N-1). It is combinational from registered state and must never depend on in_valid.
- Accept: in_valid & in_ready. This writes the shadow and sets shadow_full on the next edge.
- At ph==N-1 (symbol boundary):
  - If shadow_full: shift <= shadow, and shadow_full clears.
  - Otherwise: shift <= C_idle_symbol on all three colours, and underrun sets.
  - A same-cycle accept refills the shadow (shadow_full stays 1). The old shadow content, or the idle symbol, goes to shift; the new word goes to the next symbol.
- Output slice at each cycle, registered (1-cycle latency from ph):
  - DDR: out_x[0] = shift[2*ph], out_x[1] = shift[2*ph+1].
  - SDR: out_x[0] = shift[ph], out_x[1] = 0.
- Symbol latency: a triplet loaded into shift at boundary edge t has its bit 0 on out_x[0] in cycle t+1 (ph=0 output registered at edge t+1). It stays continuous for N cycles.
- The clock channel outputs the pattern aligned to ph and is never interrupted by underrun.
- underrun clears on clr_underrun. If clr_underrun coincides with a new underrun, set wins.
- Reset values (all synchronous):
  - ph = 0, shadow_full = 0, underrun = 0.
  - shift = C_idle_symbol on all colours; all out_* = 2'b00.
  - in_ready is 1 from the first cycle after reset deassertion.
- Reset mid-symbol: the symbol in flight and the shadow are discarded with no partial output. After reset, the first symbol is the idle symbol, starting at ph=0.
- in_valid is ignored while reset=1 (in_ready=0 during reset).
- in_* only need to be stable in the accept cycle.

Optional Feature:
- Macro TMDS_UNDERRUN_COUNT_EN.
- Defined:
  - Adds output port underrun_count [15:0]: a saturating count of inserted idle symbols.
  - Increments at each underrun boundary and holds at 16'hFFFF.
  - Cleared by reset or clr_underrun. A coincident underrun loads 1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- SDR, reset, no input → out_red[0] repeats 0,0,1,0,1,0,1,0,1,1 (C_idle LSB first) every 10 cycles; out_clock[0] gives 1 ×5 then 0 ×5; underrun=1 after the first boundary; out_x[1]=0 throughout.
- DDR, in_valid held, in_red=10'h3FF, in_green=10'h000, in_blue=10'h155 → in_ready pulses once per 5 cycles; out_red=2'b11 and out_green=2'b00 continuous; out_blue=2'b01 every cycle; underrun stays 0.
- DDR, send one triplet, then none → exactly one data symbol (5 cycles) appears between idle symbols; underrun sets at the following boundary; clr_underrun clears it.
- Backpressure: in_valid on the cycle ph==N-1 with shadow_full=1 → accept occurs; the old shadow is transmitted next and the new word after it, with no loss or duplication (scoreboard 1000 random symbols, random in_valid gaps).
- Assert reset at ph=3 mid data symbol → on the following cycles outputs are 0, then idle symbols begin at ph=0; the pending shadow word is never transmitted.
- With TMDS_UNDERRUN_COUNT_EN, no input for 70000 symbols → underrun_count saturates at 16'hFFFF; clr_underrun with a coincident underrun gives 1.
